// File: rtl/fetch_unit.sv
// fetch_unit: instruction-side responder to the controller FSM.
//
// Holds the program counter, the instruction register and a 2^ADDR_W-byte
// instruction memory. After reset the block sits in LOAD and fills memory
// from the program-load port, then switches to RUN where it honors the
// controller strobes, and finally parks in HALTED until reset.
//
// Optional feature: define FETCH_BOUNDS_EN to build the program-length
// register and the fetch bounds check that drives `fault`.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   loadIR                 capture mem[pc] into IR
//   incPC                  pc <= pc + 1
//   loadPC, selPC          load pc from regOut (selPC=0) or IR[3:0] (selPC=1)
//   halt                   go to HALTED at the next edge
//   regOut[7:0]            branch target from the register file
//   progData[7:0]          program byte
//   progValid, progLast    load-port valid and final-byte qualifier
//   progReady              load port accepting (state decode only)
//   opcode[3:0]            IR[7:4]
//   operand[3:0]           IR[3:0]
//   pc[ADDR_W-1:0]         current program counter
//   run                    controller strobes are honored
//   fault                  sticky out-of-program fetch flag
//   stateDbg[1:0]          current FSM state (0 LOAD, 1 RUN, 2 HALTED)
//
// Load-port handshake: a beat transfers on a rising edge where
// progValid && progReady are both high. progReady depends on state alone,
// so the producer may hold progValid/progData until it sees the transfer;
// there is no combinational path from progValid to progReady.
module fetch_unit #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              loadIR,
  input  logic              incPC,
  input  logic              loadPC,
  input  logic              selPC,
  input  logic              halt,
  input  logic [7:0]        regOut,
  input  logic [7:0]        progData,
  input  logic              progValid,
  input  logic              progLast,
  output logic              progReady,
  output logic [3:0]        opcode,
  output logic [3:0]        operand,
  output logic [ADDR_W-1:0] pc,
  output logic              run,
  output logic              fault,
  output logic [1:0]        stateDbg
);

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state, stateNext;
  logic [ADDR_W-1:0] pcNext;
  logic [ADDR_W-1:0] wptr, wptrNext;
  logic [7:0]        ir, irNext;
  logic [7:0]        fetchData;
  logic [7:0]        mem [0:(1<<ADDR_W)-1];
  logic              accept;
  logic              lastBeat;

  assign progReady = (state == S_LOAD);
  assign run       = (state == S_RUN);
  assign opcode    = ir[7:4];
  assign operand   = ir[3:0];
  assign stateDbg  = state;

  assign accept    = progReady && progValid;
  // The write at the top address also ends the load, since wptr would wrap.
  assign lastBeat  = accept && (progLast || (wptr == {ADDR_W{1'b1}}));
  assign fetchData = mem[pc];

  // Memory has no reset; only LOAD-state beats write it.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wptr] <= progData;
    end
  end

`ifdef FETCH_BOUNDS_EN
  logic [ADDR_W:0] plen, plenNext;
  logic            faultQ, faultNext;
  logic            outOfBounds;

  // plen is one bit wider so a full 2^ADDR_W-byte program is representable.
  assign outOfBounds = ({1'b0, pc} >= plen);
  assign fault       = faultQ;
`else
  assign fault = 1'b0;
`endif

  always_comb begin
    stateNext = state;
    pcNext    = pc;
    irNext    = ir;
    wptrNext  = wptr;
`ifdef FETCH_BOUNDS_EN
    plenNext  = plen;
    faultNext = faultQ;
`endif
    case (state)
      S_LOAD: begin
        if (accept) begin
          wptrNext = wptr + PC_ONE;
          if (lastBeat) begin
            stateNext = S_RUN;
`ifdef FETCH_BOUNDS_EN
            plenNext  = {1'b0, wptr} + {{ADDR_W{1'b0}}, 1'b1};
`endif
          end
        end
      end
      S_RUN: begin
        if (loadIR) begin
          irNext = fetchData;
`ifdef FETCH_BOUNDS_EN
          // Substitute a HALT opcode so the controller stops on its own.
          if (outOfBounds) begin
            irNext    = 8'hF0;
            faultNext = 1'b1;
          end
`endif
        end
        // loadPC has priority over incPC; the IR used is the pre-edge value.
        if (loadPC) begin
          pcNext = selPC ? ADDR_W'(ir[3:0]) : ADDR_W'(regOut);
        end else if (incPC) begin
          pcNext = pc + PC_ONE;
        end
        if (halt) begin
          stateNext = S_HALTED;
        end
      end
      default: begin
        // HALTED: everything frozen until reset.
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_LOAD;
      pc     <= '0;
      ir     <= 8'h00;
      wptr   <= '0;
`ifdef FETCH_BOUNDS_EN
      plen   <= '0;
      faultQ <= 1'b0;
`endif
    end else begin
      state  <= stateNext;
      pc     <= pcNext;
      ir     <= irNext;
      wptr   <= wptrNext;
`ifdef FETCH_BOUNDS_EN
      plen   <= plenNext;
      faultQ <= faultNext;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit (ADDR_W = 8).
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       loadIR, incPC, loadPC, selPC, halt;
  logic [7:0] regOut, progData;
  logic       progValid, progLast;
  logic       progReady;
  logic [3:0] opcode, operand;
  logic [7:0] pc;
  logic       run, fault;
  logic [1:0] stateDbg;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst),
    .loadIR(loadIR), .incPC(incPC), .loadPC(loadPC), .selPC(selPC), .halt(halt),
    .regOut(regOut), .progData(progData), .progValid(progValid), .progLast(progLast),
    .progReady(progReady), .opcode(opcode), .operand(operand), .pc(pc),
    .run(run), .fault(fault), .stateDbg(stateDbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    string      name;
    logic       lIR, iPC, lPC, sPC, hlt;
    logic [7:0] rOut;
    logic       pV;
    logic [7:0] pD;
    logic       pL;
    logic [7:0] ePc;
    logic [3:0] eOp, eOpd;
    logic       eRun, eRdy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input string name,
                              input logic lIR, input logic iPC, input logic lPC,
                              input logic sPC, input logic hlt, input logic [7:0] rOut,
                              input logic pV, input logic [7:0] pD, input logic pL,
                              input logic [7:0] ePc, input logic [3:0] eOp,
                              input logic [3:0] eOpd, input logic eRun, input logic eRdy);
    vec_t v;
    v.name = name; v.lIR = lIR; v.iPC = iPC; v.lPC = lPC; v.sPC = sPC; v.hlt = hlt;
    v.rOut = rOut; v.pV = pV; v.pD = pD; v.pL = pL;
    v.ePc = ePc; v.eOp = eOp; v.eOpd = eOpd; v.eRun = eRun; v.eRdy = eRdy;
    return v;
  endfunction

  // Program B byte pattern: i ^ 8'hA5, except address 4 holds 8'h79.
  function automatic logic [7:0] byteB(input int i);
    logic [7:0] b;
    b = 8'(i);
    if (i == 4) return 8'h79;
    return b ^ 8'hA5;
  endfunction

  // driver tasks
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idleInputs();
    loadIR = 0; incPC = 0; loadPC = 0; selPC = 0; halt = 0;
    regOut = 8'h00; progData = 8'h00; progValid = 0; progLast = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    idleInputs();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic applyRange(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      loadIR = tbl[i].lIR; incPC = tbl[i].iPC; loadPC = tbl[i].lPC;
      selPC = tbl[i].sPC; halt = tbl[i].hlt; regOut = tbl[i].rOut;
      progValid = tbl[i].pV; progData = tbl[i].pD; progLast = tbl[i].pL;
      step();
      chk({tbl[i].name, ".pc"}, 32'(pc), 32'(tbl[i].ePc));
      chk({tbl[i].name, ".opcode"}, 32'(opcode), 32'(tbl[i].eOp));
      chk({tbl[i].name, ".operand"}, 32'(operand), 32'(tbl[i].eOpd));
      chk({tbl[i].name, ".run"}, 32'(run), 32'(tbl[i].eRun));
      chk({tbl[i].name, ".progReady"}, 32'(progReady), 32'(tbl[i].eRdy));
      chk({tbl[i].name, ".fault"}, 32'(fault), 32'd0);
    end
    idleInputs();
  endtask

  initial begin
    // Program A: D5 1A F0 (indices 0..8)
    //                 name                lIR iPC lPC sPC hlt rOut   pV pD     pL  ePc    op    opd   run rdy
    tbl.push_back(mk("idle_load",          0,  0,  0,  0,  0,  8'h00, 0, 8'h00, 0,  8'h00, 4'h0, 4'h0, 0,  1));
    tbl.push_back(mk("strobes_in_load",    1,  1,  1,  0,  1,  8'h55, 0, 8'h00, 0,  8'h00, 4'h0, 4'h0, 0,  1));
    tbl.push_back(mk("beat0",              0,  0,  0,  0,  0,  8'h00, 1, 8'hD5, 0,  8'h00, 4'h0, 4'h0, 0,  1));
    tbl.push_back(mk("beat1",              0,  0,  0,  0,  0,  8'h00, 1, 8'h1A, 0,  8'h00, 4'h0, 4'h0, 0,  1));
    tbl.push_back(mk("beat2_last",         0,  0,  0,  0,  0,  8'h00, 1, 8'hF0, 1,  8'h00, 4'h0, 4'h0, 1,  0));
    tbl.push_back(mk("fetch0",             1,  1,  0,  0,  0,  8'h00, 0, 8'h00, 0,  8'h01, 4'hD, 4'h5, 1,  0));
    tbl.push_back(mk("progValid_in_run",   0,  0,  0,  0,  0,  8'h00, 1, 8'h99, 1,  8'h01, 4'hD, 4'h5, 1,  0));
    tbl.push_back(mk("fetch1",             1,  1,  0,  0,  0,  8'h00, 0, 8'h00, 0,  8'h02, 4'h1, 4'hA, 1,  0));
    tbl.push_back(mk("fetch2",             1,  1,  0,  0,  0,  8'h00, 0, 8'h00, 0,  8'h03, 4'hF, 4'h0, 1,  0));
    // Program B: 256 bytes, branch/halt sequence (indices 9..19)
    tbl.push_back(mk("first_fetch_B",      1,  1,  0,  0,  0,  8'h00, 0, 8'h00, 0,  8'h01, 4'hA, 4'h5, 1,  0));
    tbl.push_back(mk("jump_reg4",          0,  0,  1,  0,  0,  8'h04, 0, 8'h00, 0,  8'h04, 4'hA, 4'h5, 1,  0));
    tbl.push_back(mk("fetch4",             1,  0,  0,  0,  0,  8'h00, 0, 8'h00, 0,  8'h04, 4'h7, 4'h9, 1,  0));
    tbl.push_back(mk("inc_and_loadpc",     0,  1,  1,  1,  0,  8'h00, 0, 8'h00, 0,  8'h09, 4'h7, 4'h9, 1,  0));
    tbl.push_back(mk("jump_reg20",         0,  0,  1,  0,  0,  8'h20, 0, 8'h00, 0,  8'h20, 4'h7, 4'h9, 1,  0));
    tbl.push_back(mk("fetch32",            1,  0,  0,  0,  0,  8'h00, 0, 8'h00, 0,  8'h20, 4'h8, 4'h5, 1,  0));
    tbl.push_back(mk("jump_regff",         0,  0,  1,  0,  0,  8'hFF, 0, 8'h00, 0,  8'hFF, 4'h8, 4'h5, 1,  0));
    tbl.push_back(mk("fetch_ff_wrap",      1,  1,  0,  0,  0,  8'h00, 0, 8'h00, 0,  8'h00, 4'h5, 4'hA, 1,  0));
    tbl.push_back(mk("halt_with_inc",      0,  1,  0,  0,  1,  8'h00, 0, 8'h00, 0,  8'h01, 4'h5, 4'hA, 0,  0));
    tbl.push_back(mk("halted_pulses",      1,  1,  1,  1,  0,  8'h33, 1, 8'h00, 1,  8'h01, 4'h5, 4'hA, 0,  0));
    tbl.push_back(mk("halted_again",       1,  0,  0,  0,  1,  8'h00, 1, 8'h77, 0,  8'h01, 4'h5, 4'hA, 0,  0));

    idleInputs();
    doReset();

    // reset state
    chk("reset.pc", 32'(pc), 32'h0);
    chk("reset.opcode", 32'(opcode), 32'h0);
    chk("reset.operand", 32'(operand), 32'h0);
    chk("reset.progReady", 32'(progReady), 32'h1);
    chk("reset.run", 32'(run), 32'h0);
    chk("reset.fault", 32'(fault), 32'h0);

    // program A and in-order fetches
    applyRange(0, 8);

    // fetch at pc == plen
    loadIR = 1;
    step();
    idleInputs();
    chk("bounds.pc", 32'(pc), 32'h3);
`ifdef FETCH_BOUNDS_EN
    chk("bounds.opcode", 32'(opcode), 32'hF);
    chk("bounds.operand", 32'(operand), 32'h0);
    chk("bounds.fault", 32'(fault), 32'h1);
    step();
    chk("bounds.fault_sticky", 32'(fault), 32'h1);
`else
    chk("bounds.fault", 32'(fault), 32'h0);
`endif

    // program B: full 256-byte load ends without progLast
    doReset();
    for (int i = 0; i < 256; i++) begin
      progValid = 1; progData = byteB(i); progLast = 0;
      step();
      if (i >= 253) begin
        chk($sformatf("fullload.progReady[%0d]", i), 32'(progReady), (i < 255) ? 32'h1 : 32'h0);
        chk($sformatf("fullload.run[%0d]", i), 32'(run), (i == 255) ? 32'h1 : 32'h0);
      end
    end
    idleInputs();
    applyRange(9, 19);

    // asynchronous reset, no clock edge needed
    rst = 1'b1;
    #2;
    chk("async_rst.pc", 32'(pc), 32'h0);
    chk("async_rst.opcode", 32'(opcode), 32'h0);
    chk("async_rst.progReady", 32'(progReady), 32'h1);
    chk("async_rst.run", 32'(run), 32'h0);
    step();
    rst = 1'b0;

    // abandon a load after 2 of 5 beats
    progValid = 1; progData = 8'h11; step();
    progValid = 1; progData = 8'h22; step();
    chk("midload.progReady", 32'(progReady), 32'h1);
    progData = 8'h33;
    rst = 1'b1;
    #2;
    chk("midload_rst.pc", 32'(pc), 32'h0);
    chk("midload_rst.opcode", 32'(opcode), 32'h0);
    chk("midload_rst.operand", 32'(operand), 32'h0);
    chk("midload_rst.progReady", 32'(progReady), 32'h1);
    idleInputs();
    step();
    rst = 1'b0;

    // reload must start at address 0
    progValid = 1; progData = 8'h3C; step();
    progValid = 1; progData = 8'h4D; progLast = 1; step();
    idleInputs();
    chk("reload.run", 32'(run), 32'h1);
    loadIR = 1; incPC = 1; step();
    idleInputs();
    chk("reload.opcode", 32'(opcode), 32'h3);
    chk("reload.operand", 32'(operand), 32'hC);
    chk("reload.pc", 32'(pc), 32'h1);
    loadIR = 1; step();
    idleInputs();
    chk("reload.opcode1", 32'(opcode), 32'h4);
    chk("reload.operand1", 32'(operand), 32'hD);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
